// File: rtl/des_ks_pkg.sv
// des_ks_pkg: shared definitions for the DES key schedule.
// Contents:
//   ks_state_e      - key-stream controller states (IDLE, RUN)
//   SHIFT_TBL       - left-rotation amount per round, index 0 = round 1
//   PC1_TBL/PC2_TBL - FIPS 46-3 permuted-choice tables, 1-based DES bit numbers
//   rotl28/rotr28   - rotate one 28-bit key half by 0..2 positions
// Bit convention: vector MSB is DES bit 1.
package des_ks_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // DES left rotation moves bit 1 (the MSB) to bit 28 (the LSB).
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_ks_pc2.sv
// des_ks_pc2: DES permuted choice 2. It selects 48 of the 56 C||D bits to
// form a round key.
// Ports:
//   cd    in  56  C||D, cd[55] = DES bit 1
//   rkey  out 48  round key, rkey[47] = DES bit 1
module des_ks_pc2
  import des_ks_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] rkey
);

  for (genvar j = 0; j < 48; j++) begin : g_bit
    assign rkey[47-j] = cd[56-PC2_TBL[j]];
  end

  // PC-2 drops DES bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic unused_dropped;
  assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                            cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/perm1.sv
// perm1: DES permuted choice 1. It drops the eight parity bits and reorders
// the key into the C (cd[55:28]) and D (cd[27:0]) halves.
// Ports:
//   key  in  64  DES key with parity, key[63] = DES bit 1
//   cd   out 56  C||D, cd[55] = C bit 1
module perm1
  import des_ks_pkg::*;
(
  input  logic [63:0] key,
  output logic [55:0] cd
);

  for (genvar j = 0; j < 56; j++) begin : g_bit
    assign cd[55-j] = key[64-PC1_TBL[j]];
  end

  // PC-1 never selects the parity bits (DES bits 8, 16, ..., 64).
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

endmodule

// File: rtl/des_key_stream.sv
// des_key_stream: accepts one DES key and streams its 16 round keys with
// valid/ready handshakes. Keys come out in K1..K16 order for encryption
// and in K16..K1 order for decryption.
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   key_valid/key_ready     key input handshake (KEY, decrypt)
//   KEY[63:0]               DES key with parity, KEY[63] = DES bit 1
//   decrypt                 0 = K1..K16, 1 = K16..K1
//   rkey_valid/rkey_ready   round-key output handshake
//   r_key[47:0]             current round key
//   round[3:0]              DES round number minus 1 for r_key
//   last                    r_key is the final key of the sequence
//   parity_err              odd-parity violation on the accepted KEY
// Build option: define DES_KEY_PARITY_CHK_EN to enable the parity check.
// Without it, parity_err is tied to 0.
module des_key_stream
  import des_ks_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] KEY,
  input  logic        decrypt,
  output logic        rkey_valid,
  input  logic        rkey_ready,
  output logic [47:0] r_key,
  output logic [3:0]  round,
  output logic        last,
  output logic        parity_err
);

  ks_state_e   state, state_next;
  logic [27:0] c, d;
  logic        mode;
  logic [55:0] pc1_cd;
  logic [27:0] c_next, d_next;
  logic [3:0]  round_next;
  logic [47:0] pc2_key;
  logic        accept, advance;

  perm1 u_pc1 (
    .key (KEY),
    .cd  (pc1_cd)
  );

  des_ks_pc2 u_pc2 (
    .cd   ({c_next, d_next}),
    .rkey (pc2_key)
  );

  assign key_ready  = (state == IDLE);
  assign rkey_valid = (state == RUN);
  assign accept     = key_valid && key_ready;
  assign advance    = rkey_valid && rkey_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_valid) state_next = RUN;
      RUN:     if (rkey_ready && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next C/D and round index. A single PC-2 instance serves both the first
  // key (from PC-1 of KEY) and every later key (from the stored C/D).
  // Decryption starts from the unrotated C0/D0 because 16 encrypt rotations
  // total 28, which brings C16/D16 back to C0/D0.
  always_comb begin
    c_next     = c;
    d_next     = d;
    round_next = round;
    if (state == IDLE) begin
      if (decrypt) begin
        c_next     = pc1_cd[55:28];
        d_next     = pc1_cd[27:0];
        round_next = 4'hf;
      end else begin
        c_next     = rotl28(pc1_cd[55:28], 2'd1);
        d_next     = rotl28(pc1_cd[27:0], 2'd1);
        round_next = 4'h0;
      end
    end else if (mode) begin
      // Undo the rotation that produced the current round.
      c_next     = rotr28(c, SHIFT_TBL[round]);
      d_next     = rotr28(d, SHIFT_TBL[round]);
      round_next = round - 4'd1;
    end else begin
      round_next = round + 4'd1;
      c_next     = rotl28(c, SHIFT_TBL[round_next]);
      d_next     = rotl28(d, SHIFT_TBL[round_next]);
    end
  end

  // The output registers move only on accept or on a handshake of a
  // non-final key. This holds them stable under backpressure, and keeps
  // them at the final key once the block has returned to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c     <= '0;
      d     <= '0;
      mode  <= 1'b0;
      r_key <= '0;
      round <= '0;
      last  <= 1'b0;
    end else if (accept) begin
      c     <= c_next;
      d     <= d_next;
      mode  <= decrypt;
      r_key <= pc2_key;
      round <= round_next;
      last  <= 1'b0;
    end else if (advance && !last) begin
      c     <= c_next;
      d     <= d_next;
      r_key <= pc2_key;
      round <= round_next;
      last  <= mode ? (round_next == 4'h0) : (round_next == 4'hf);
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  // Every DES key byte must have odd parity. A byte with even parity sets
  // the flag, and the flag holds until the next key is accepted.
  logic parity_bad;
  assign parity_bad = ~^KEY[63:56] | ~^KEY[55:48] | ~^KEY[47:40] | ~^KEY[39:32] |
                      ~^KEY[31:24] | ~^KEY[23:16] | ~^KEY[15:8]  | ~^KEY[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n)      parity_err <= 1'b0;
    else if (accept) parity_err <= parity_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/des_key_stream.md
DES_KEY_STREAM -- requirements
Module: des_key_stream

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_valid  in  1  KEY and decrypt presented.
- key_ready  out  1  block can accept a new key.
- KEY  in  64  DES key including parity bits, bit 63 = DES bit 1.
- decrypt  in  1  0 = encrypt order K1..K16; 1 = decrypt order K16..K1.
- rkey_valid  out  1  r_key is valid.
- rkey_ready  in  1  consumer accepts r_key.
- r_key  out  48  current round key (PC-2 output).
- round  out  4  DES round number minus 1 of r_key (4'h0 = K1 ... 4'hf = K16).
- last  out  1  r_key is the final key of the sequence.
- parity_err  out  1  odd-parity violation on the accepted KEY.
REQ-002 The block SHALL have no parameters; the shift table, PC-1 and PC-2 SHALL be fixed to FIPS 46-3.

Function
REQ-003 FSM states SHALL be IDLE and RUN; key_ready SHALL equal (state == IDLE); rkey_valid SHALL equal (state == RUN).
REQ-004 Key accept SHALL occur when key_valid && key_ready; on accept, PC-1 of KEY SHALL be latched into C/D (28+28 bits), decrypt SHALL be latched as mode, and the FSM SHALL enter RUN.
REQ-005 The first r_key SHALL be valid in the cycle after accept (1-cycle latency). r_key, round and last SHALL be registered.
REQ-006 Encrypt: output for round r (1..16) SHALL be PC-2(rotl(C,S[r]) || rotl(D,S[r])), with S = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, and C/D updated to the rotated value.
REQ-007 Decrypt: the first output SHALL be K16 = PC-2(C0||D0). Each subsequent output for round r = 15..1 SHALL be PC-2 of C/D rotated right by S[r+1], with C/D updated.
REQ-008 The block SHALL advance to the next key only on rkey_valid && rkey_ready. While rkey_ready is low, r_key, round and last SHALL hold stable.
REQ-009 last SHALL be 1 exactly when round == 4'hf (encrypt) or round == 4'h0 (decrypt). A handshake with last = 1 SHALL return the FSM to IDLE on the next cycle, with rkey_valid = 0 and key_ready = 1.
REQ-010 key_valid asserted during RUN SHALL be ignored; no new key SHALL be accepted before the current sequence completes.
REQ-011 After 16 rotations in encrypt mode, C/D SHALL equal C0/D0 (total rotation 28); rotation SHALL wrap modulo 28 per half.

Reset
REQ-012 With rst_n low at a clock edge, the FSM SHALL go to IDLE and C, D, mode, r_key, round, last and parity_err SHALL all be cleared to 0; this holds mid-sequence, with no key emitted afterwards.
REQ-013 With rst_n low, key_ready SHALL read 0 in that cycle's outputs only via state, i.e. 1 from the cycle after reset.

Configuration
REQ-014 Macro DES_KEY_PARITY_CHK_EN: when defined, on accept parity_err SHALL be set to 1 if any KEY byte has even parity; otherwise it SHALL be set to 0. parity_err SHALL hold until the next accept. The key SHALL be processed regardless of parity_err.
REQ-015 Without DES_KEY_PARITY_CHK_EN, the parity_err port SHALL remain present and tied to 0.

Structure
REQ-016 Package des_ks_pkg SHALL hold the S shift table, the PC-1 and PC-2 index tables, and the FSM state enum.
REQ-017 PC-1 SHALL reuse the existing perm1 module.
REQ-018 PC-2 SHALL be a new combinational sub-module des_ks_pc2 (56-bit in, 48-bit out).

Verification
REQ-019 Encrypt test: KEY = 64'h133457799BBCDFF1, decrypt = 0, rkey_ready = 1. Required: first r_key = 48'h1B02EFFC7072 with round 0, sixteenth r_key = 48'hCB3D8B0E17F5 with last = 1, parity_err = 0.
REQ-020 Decrypt test: same key with decrypt = 1. Required: first r_key = 48'hCB3D8B0E17F5 with round 4'hf, final r_key = 48'h1B02EFFC7072 with round 0 and last = 1; the sequence SHALL be the exact reverse of REQ-019.
REQ-021 Backpressure test: drop rkey_ready for 5 cycles at round 4'h3. Required: r_key, round and last hold stable, and the sequence resumes with no skipped or repeated key.
REQ-022 Reset mid-run: pulse rst_n low at round 4'h7. Required: next cycle rkey_valid = 0 and r_key = 0, then key_ready = 1; a new key is accepted and starts at round 0.
REQ-023 Back-to-back test: key_valid held high with two keys queued. Required: the second key is accepted in the first IDLE cycle after last; key_valid during RUN is ignored.
REQ-024 Parity test with DES_KEY_PARITY_CHK_EN defined: KEY = 64'h133457799BBCDFF0. Required: parity_err = 1 and the keys are still generated. Without the macro, parity_err = 0.
